// File: rtl/bram.sv
// bram: single-port block RAM with synchronous, registered read.
// One address serves both reads and writes. The read is read-first: on a
// write cycle o_data shows the word that was stored before the write.
// Memory contents are never cleared; reset only zeroes the output register.
module bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_data;

    // Storage write port. It has no reset, so it maps onto block RAM, and a
    // write asserted together with reset still lands in the array.
    always_ff @(posedge i_clk) begin
        if (i_write) begin
            r_mem[i_addr] <= i_data;
        end
    end

    // Registered read port. It samples the array before this edge's write
    // takes effect, which gives read-first behaviour. Reset takes priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
        end else begin
            r_data <= r_mem[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: tb/tb_bram.sv
// tb_bram: directed, table-driven checks of the bram, covering both the
// default geometry and a 16 x 32 instance.
module tb_bram;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic        write;
    logic [63:0] wdata;
    logic [63:0] rdata;

    logic [3:0]  sAddr;
    logic        sWrite;
    logic [31:0] sData;
    logic [31:0] sRdata;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [7:0]  a;
        logic [63:0] d;
        logic        chk;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[18];

    bram #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_addr  (addr),
        .i_write (write),
        .i_data  (wdata),
        .o_data  (rdata)
    );

    bram #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dutSmall (
        .i_clk   (clk),
        .i_reset (reset),
        .i_addr  (sAddr),
        .i_write (sWrite),
        .i_data  (sData),
        .o_data  (sRdata)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value with its expected value and keep the tallies
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive the large instance for one cycle and sample #1 after the edge
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [7:0] a, input logic [63:0] d);
        reset = r;
        write = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        sAddr  = '0;
        sWrite = 1'b0;
        sData  = '0;

        //            rst   wr    addr   data                    chk   expected
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 64'hdeadbeef00000000, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, 64'habad1deac0fef00d, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 1'b0, 8'h01, 64'h0,                1'b1, 64'habad1deac0fef00d};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 64'h0,                1'b1, 64'hdeadbeef00000000};
        vecs[4]  = '{1'b0, 1'b0, 8'h01, 64'h0,                1'b1, 64'habad1deac0fef00d};
        vecs[5]  = '{1'b0, 1'b1, 8'h05, 64'h1111111111111111, 1'b0, 64'h0};
        vecs[6]  = '{1'b0, 1'b1, 8'h05, 64'h2222222222222222, 1'b1, 64'h1111111111111111};
        vecs[7]  = '{1'b0, 1'b0, 8'h05, 64'h0,                1'b1, 64'h2222222222222222};
        vecs[8]  = '{1'b0, 1'b1, 8'h03, 64'h0123456789abcdef, 1'b0, 64'h0};
        vecs[9]  = '{1'b1, 1'b0, 8'h03, 64'h0,                1'b1, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 8'h03, 64'h0,                1'b1, 64'h0123456789abcdef};
        vecs[11] = '{1'b1, 1'b1, 8'h07, 64'h7777777777777777, 1'b1, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 8'h07, 64'h0,                1'b1, 64'h7777777777777777};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 64'ha5a5a5a5a5a5a5a5, 1'b1, 64'hdeadbeef00000000};
        vecs[14] = '{1'b0, 1'b1, 8'hff, 64'h5a5a5a5a0f0f0f0f, 1'b0, 64'h0};
        vecs[15] = '{1'b0, 1'b0, 8'hff, 64'h0,                1'b1, 64'h5a5a5a5a0f0f0f0f};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 64'h0,                1'b1, 64'ha5a5a5a5a5a5a5a5};
        vecs[17] = '{1'b0, 1'b0, 8'hff, 64'h0,                1'b1, 64'h5a5a5a5a0f0f0f0f};

        // Reset state of both instances
        applyStimulus(1'b1, 1'b0, 8'h00, 64'h0);
        checkOutput("resetLarge", rdata, 64'h0);
        checkOutput("resetSmall", {32'h0, sRdata}, 64'h0);

        // Table-driven directed vectors
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // o_data must not follow i_addr between edges
        applyStimulus(1'b0, 1'b0, 8'h05, 64'h0);
        checkOutput("holdBefore", rdata, 64'h2222222222222222);
        addr = 8'h01;
        #3;
        checkOutput("holdAfterAddrChange", rdata, 64'h2222222222222222);
        @(posedge clk);
        #1;
        checkOutput("holdNextEdge", rdata, 64'habad1deac0fef00d);

        // Full sweep: back-to-back writes, then back-to-back reads
        for (int a = 0; a < 256; a++) begin
            applyStimulus(1'b0, 1'b1, 8'(a), {8{8'(a)}});
        end
        for (int a = 0; a < 256; a++) begin
            applyStimulus(1'b0, 1'b0, 8'(a), 64'h0);
            checkOutput($sformatf("sweep%0d", a), rdata, {8{8'(a)}});
        end
        write = 1'b0;

        // Parameter variant: 16 x 32
        sWrite = 1'b1;
        sAddr  = 4'hf;
        sData  = 32'hcafef00d;
        @(posedge clk);
        #1;
        sAddr  = 4'h0;
        sData  = 32'h12345678;
        @(posedge clk);
        #1;
        sWrite = 1'b0;
        sAddr  = 4'hf;
        @(posedge clk);
        #1;
        checkOutput("smallAddr15", {32'h0, sRdata}, {32'h0, 32'hcafef00d});
        sAddr = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("smallAddr0", {32'h0, sRdata}, {32'h0, 32'h12345678});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
